// File: rtl/cipher_stream_ctrl.sv
// ----------------------------------------------------------------------------
// cipher_stream_ctrl
//
// Purpose:
//   Sequences a byte-wise cipher core. Bytes arrive on a valid/ready input
//   stream. Newline bytes are optionally dropped. Each remaining byte goes to
//   the core as one operation, using a rolling key (frame base key plus the
//   byte index). Results leave on a valid/ready output stream. At most one
//   byte is in flight at any time.
//
// Parameters:
//   SKIP_CHAR  byte value that is dropped when skip_en=1
//   CNT_W      width of byte_count (must be at least 8)
//   TIMEOUT    number of WAIT cycles allowed before the core is abandoned
//              (1..255)
//
// Ports:
//   clk, reset               rising-edge clock, synchronous active-high reset
//   cfg_key                  base key, sampled on the first issued byte of a frame
//   skip_en                  1 = drop SKIP_CHAR bytes
//   in_valid/in_data/in_last/in_ready     input byte stream
//   core_start/core_din/core_key          request to the cipher core
//   core_done/core_dout                   result from the cipher core
//   out_valid/out_data/out_last/out_ready result byte stream
//   frame_done               one-cycle pulse after a frame completes
//   byte_count               bytes completed by the core in the current frame
//   error                    sticky flag, set when the core times out
// ----------------------------------------------------------------------------
module cipher_stream_ctrl #(
    parameter logic [7:0] SKIP_CHAR = 8'h0A,
    parameter int         CNT_W     = 16,
    parameter int         TIMEOUT   = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       cfg_key,
    input  logic             skip_en,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             core_start,
    output logic [7:0]       core_din,
    output logic [7:0]       core_key,
    input  logic             core_done,
    input  logic [7:0]       core_dout,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             frame_done,
    output logic [CNT_W-1:0] byte_count,
    output logic             error
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_e;

    localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q;
    logic             in_ready_q;
    logic             core_start_q;
    logic [7:0]       core_din_q;
    logic [7:0]       core_key_q;
    logic             out_valid_q;
    logic [7:0]       out_data_q;
    logic             out_last_q;
    logic             frame_done_q;
    logic [CNT_W-1:0] byte_count_q;
    logic             error_q;
    logic [7:0]       key_base_q;
    logic             last_q;
    logic [7:0]       tmo_q;

    logic [7:0]       key_base_d;
    logic [7:0]       key_d;

    // The first issued byte of a frame takes cfg_key directly; later bytes
    // reuse the captured base so mid-frame cfg_key changes have no effect.
    assign key_base_d = (byte_count_q == '0) ? cfg_key : key_base_q;
    assign key_d      = key_base_d + byte_count_q[7:0];

    // NOTE: every register below is written with <= so all of them update
    // together from the same pre-edge values; a blocking = here would let
    // later statements see half-updated state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b0;
            core_start_q <= 1'b0;
            core_din_q   <= '0;
            core_key_q   <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            byte_count_q <= '0;
            error_q      <= 1'b0;
            key_base_q   <= '0;
            last_q       <= 1'b0;
            tmo_q        <= '0;
        end else begin
            // Single-cycle pulses.
            core_start_q <= 1'b0;
            frame_done_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        if (skip_en && (in_data == SKIP_CHAR)) begin
                            // A dropped byte can still close the frame.
                            if (in_last) begin
                                frame_done_q <= 1'b1;
                                byte_count_q <= '0;
                            end
                        end else begin
                            // Start is registered here so it is high
                            // for exactly the ISSUE cycle.
                            core_din_q   <= in_data;
                            core_key_q   <= key_d;
                            key_base_q   <= key_base_d;
                            last_q       <= in_last;
                            core_start_q <= 1'b1;
                            in_ready_q   <= 1'b0;
                            state_q      <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    tmo_q   <= '0;
                    state_q <= WAIT;
                end

                WAIT: begin
                    if (core_done) begin
                        out_data_q   <= core_dout;
                        out_last_q   <= last_q;
                        out_valid_q  <= 1'b1;
                        byte_count_q <= byte_count_q + CNT_ONE;
                        state_q      <= OUT;
                    end else if (tmo_q == TMO_LAST) begin
                        // The core is abandoned: the byte is lost and the
                        // next byte starts a fresh frame key.
                        error_q      <= 1'b1;
                        byte_count_q <= '0;
                        in_ready_q   <= 1'b1;
                        state_q      <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end

                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                        if (out_last_q) begin
                            frame_done_q <= 1'b1;
                            byte_count_q <= '0;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign core_start = core_start_q;
    assign core_din   = core_din_q;
    assign core_key   = core_key_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;
    assign byte_count = byte_count_q;
    assign error      = error_q;

endmodule

// File: tb/tb_cipher_stream_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cipher_stream_ctrl
//
// Directed bench for cipher_stream_ctrl. A behavioural core returns
// dout = din ^ key two cycles after start; it can be disabled to force a
// timeout. Inputs are driven and outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_cipher_stream_ctrl;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 15;

    logic             clk;
    logic             reset;
    logic [7:0]       cfg_key;
    logic             skip_en;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_last;
    logic             in_ready;
    logic             core_start;
    logic [7:0]       core_din;
    logic [7:0]       core_key;
    logic             core_done;
    logic [7:0]       core_dout;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_last;
    logic             out_ready;
    logic             frame_done;
    logic [CNT_W-1:0] byte_count;
    logic             error;

    cipher_stream_ctrl #(
        .SKIP_CHAR (8'h0A),
        .CNT_W     (CNT_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_key    (cfg_key),
        .skip_en    (skip_en),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .core_start (core_start),
        .core_din   (core_din),
        .core_key   (core_key),
        .core_done  (core_done),
        .core_dout  (core_dout),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .frame_done (frame_done),
        .byte_count (byte_count),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: done two cycles after start; never reset, so a pending
    // done can land after a controller reset.
    logic [1:0] pipe  = '0;
    logic [7:0] m_din = '0;
    logic [7:0] m_key = '0;
    logic       core_en;

    always @(posedge clk) begin
        pipe <= {pipe[0], core_start === 1'b1};
        if (core_start === 1'b1) begin
            m_din <= core_din;
            m_key <= core_key;
        end
    end

    assign core_done = pipe[1] & core_en;
    assign core_dout = m_din ^ m_key;

    // Event counters, sampled on the rising edge (each counts the cycle just
    // completed).
    int start_cnt = 0;
    int fd_cnt    = 0;
    int ov_cnt    = 0;

    always @(posedge clk) begin
        if (core_start === 1'b1) start_cnt++;
        if (frame_done === 1'b1) fd_cnt++;
        if (out_valid === 1'b1)  ov_cnt++;
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send(input logic [7:0] d, input logic l, input string tag);
        int n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rdy"}, in_ready, 1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_v"}, out_valid, 1);
    endtask

    // Expects out_ready=1; checks the result and the frame_done that follows.
    task automatic recv(input logic [7:0] d, input logic l, input string tag);
        wait_out(tag);
        check({tag, "_d"}, out_data, d);
        check({tag, "_l"}, out_last, l);
        @(negedge clk);
        check({tag, "_fd"}, frame_done, l);
    endtask

    int s0, f0, o0, n;

    initial begin
        // 1: reset held 3 cycles with inputs toggling.
        reset     = 1'b1;
        core_en   = 1'b1;
        cfg_key   = 8'h5A;
        skip_en   = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        in_last   = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            in_valid  = ~in_valid;
            in_data   = ~in_data;
            in_last   = ~in_last;
            skip_en   = ~skip_en;
            out_ready = ~out_ready;
            cfg_key   = ~cfg_key;
        end
        check("rst_flags", {in_ready, core_start, out_valid, out_last, frame_done, error}, 0);
        check("rst_din",   core_din,   0);
        check("rst_key",   core_key,   0);
        check("rst_dout",  out_data,   0);
        check("rst_cnt",   byte_count, 0);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        skip_en   = 1'b0;
        out_ready = 1'b1;
        reset     = 1'b0;
        @(negedge clk);
        check("rel_rdy", in_ready, 1);

        // 2: key 10, "ABC"; cfg_key change mid-frame must be ignored.
        cfg_key = 8'h10;
        f0 = fd_cnt;
        send(8'h41, 1'b0, "t2a");
        cfg_key = 8'h77;
        recv(8'h51, 1'b0, "t2a");
        check("t2_cnt1", byte_count, 1);
        send(8'h42, 1'b0, "t2b");
        recv(8'h53, 1'b0, "t2b");
        send(8'h43, 1'b1, "t2c");
        recv(8'h51, 1'b1, "t2c");
        check("t2_cnt0", byte_count, 0);
        repeat (2) @(negedge clk);
        check("t2_fdcnt", fd_cnt - f0, 1);

        // 3: skip LF, key 00.
        skip_en = 1'b1;
        cfg_key = 8'h00;
        s0 = start_cnt;
        send(8'h48, 1'b0, "t3h");
        recv(8'h48, 1'b0, "t3h");
        send(8'h0A, 1'b0, "t3lf");
        out_ready = 1'b0;
        send(8'h69, 1'b1, "t3i");
        wait_out("t3w");
        check("t3_cnt2", byte_count, 2);
        out_ready = 1'b1;
        recv(8'h68, 1'b1, "t3i");
        check("t3_cnt0", byte_count, 0);
        check("t3_starts", start_cnt - s0, 2);

        // 4: output back-pressure for 10 cycles.
        skip_en   = 1'b0;
        cfg_key   = 8'h20;
        out_ready = 1'b0;
        s0 = start_cnt;
        send(8'h0F, 1'b1, "t4");
        wait_out("t4w");
        repeat (10) begin
            @(negedge clk);
            check("t4_hold", {out_valid, out_last, in_ready, out_data}, {1'b1, 1'b1, 1'b0, 8'h2F});
        end
        check("t4_starts", start_cnt - s0, 1);
        out_ready = 1'b1;
        recv(8'h2F, 1'b1, "t4");

        // 5: key wrap FE, FF, 00.
        cfg_key = 8'hFE;
        send(8'h00, 1'b0, "t5a");
        recv(8'hFE, 1'b0, "t5a");
        send(8'h00, 1'b0, "t5b");
        recv(8'hFF, 1'b0, "t5b");
        send(8'h00, 1'b1, "t5c");
        recv(8'h00, 1'b1, "t5c");

        // 6a: core never answers -> timeout abort, then normal operation.
        core_en = 1'b0;
        cfg_key = 8'h33;
        o0 = ov_cnt;
        send(8'h01, 1'b0, "t6");
        repeat (12) @(negedge clk);
        check("t6_err_early", error, 0);
        check("t6_busy", in_ready, 0);
        n = 0;
        while (error !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t6_err", error, 1);
        check("t6_idle", in_ready, 1);
        check("t6_cnt", byte_count, 0);
        check("t6_noout", ov_cnt - o0, 0);
        core_en = 1'b1;
        cfg_key = 8'h40;
        send(8'h05, 1'b1, "t6n");
        recv(8'h45, 1'b1, "t6n");
        check("t6_sticky", error, 1);

        // 6b: reset while in WAIT; the late core_done must be ignored.
        o0 = ov_cnt;
        send(8'h07, 1'b1, "t6r");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6r_done_late", core_done, 1);
        repeat (10) @(negedge clk);
        check("t6r_noout", ov_cnt - o0, 0);
        check("t6r_err", error, 0);
        check("t6r_idle", in_ready, 1);
        check("t6r_cnt", byte_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
